gpu_read_port: RTL and testbench
================================

Name: gpu_read_port

Overview:
CPU-side readback path for the GPU memories, the read-direction counterpart of the GPU write bus interface. It snoops CPU writes to the pointer/increment registers, prefetches the byte at the read pointer from tile, attribute or color memory, and presents it on the data-port register with post-read auto-increment. Everything runs in the GPU clk domain; cpu_clk is treated as a sampled input.

Parameters:
SYNC_STAGES, 2, flip-flop stages used to synchronize cpu_clk into clk.
MEM_READ_LATENCY, 1, clk cycles from read address/enable to valid read data, identical for all three memories.

Ports:
clk  input  1  GPU clock, single clock domain.
rst  input  1  asynchronous, active-low reset.
cpu_clk  input  1  CPU phase-2 clock, sampled only.
cs  input  1  chip select, active low.
rw  input  1  1 = CPU read, 0 = CPU write.
addr  input  3  register select.
data_in  input  8  CPU write data, snooped.
data_out  output  8  CPU read data.
data_out_enable  output  1  drive-enable for the CPU data bus.
tile_memory_read_enable  output  1  tile memory read strobe.
tile_memory_read_addr  output  11  tile memory read address.
tile_memory_read_data  input  8  tile memory read data.
attribute_memory_read_enable  output  1  attribute memory read strobe.
attribute_memory_read_addr  output  12  attribute memory read address.
attribute_memory_read_data  input  8  attribute memory read data.
color_memory_read_enable  output  1  color memory read strobe.
color_memory_read_addr  output  4  color memory read address.
color_memory_read_data  input  8  color memory read data.

Behaviour:
- Reset (rst low, async) sets: read_pointer=0x0000, increment=0x01, read_latch=0x00, valid=0, state=IDLE, all read enables=0, all read addresses=0, sync chain=0. A prefetch of address 0x0000 is started on the first clk after rst deasserts.
- cpu_clk passes through SYNC_STAGES flops. The end of a CPU cycle is a detected falling edge of the synchronized cpu_clk. cs, rw, addr and data_in are sampled on that clk edge, and all register side effects are applied there.
- Snooped writes (cs=0, rw=0):
  - addr 3: increment <= data_in.
  - addr 4: pointer[7:0] <= data_in, then restart prefetch.
  - addr 5: pointer[15:8] <= data_in, then restart prefetch.
  - Other addresses: ignored.
- CPU reads are combinational from the latches:
  - data_out_enable = ~cs & rw & (addr==6 | addr==7).
  - addr 6: data_out = read_latch.
  - addr 7: data_out = {6'b0, busy, valid}, where busy = (state != IDLE).
  - Other addresses: data_out = 0x00.
- Read of addr 6 at end of cycle: pointer <= pointer + {8'h00, increment}, modulo 2^16 (0xFFFF + 1 wraps to 0x0000). valid <= 0 and prefetch restarts at the new pointer. With increment=0 the pointer is unchanged and the same address is refetched.
- Address decode, same map as the write side:
  - pointer < 0x0800: tile memory, addr = pointer[10:0].
  - 0x0800 <= pointer < 0x1800: attribute memory, addr = (pointer - 0x0800)[11:0].
  - pointer >= 0x1800: color memory, addr = pointer[3:0].
  - The target is latched at REQ.
- FSM:
  - IDLE: waits for a trigger.
  - REQ: exactly one enable asserted for 1 clk, with address.
  - WAIT: counts MEM_READ_LATENCY-1 cycles; with latency 1 it is skipped.
  - LATCH: read_latch <= selected memory data, valid <= 1, go to IDLE.
  - Latency from trigger to valid = 2 + (MEM_READ_LATENCY-1) clk.
- Retrigger during REQ/WAIT/LATCH aborts the in-flight fetch. Its data is discarded, valid stays 0, and the FSM re-enters REQ on the next clk with the new pointer.
- Simultaneous read of addr 6 while valid=0: CPU receives the stale read_latch. Software polls addr 7 bit0 first; no stall is generated.
- Reset mid-fetch: everything returns to reset values immediately, with no memory strobe after rst falls.

Test Plan:
- Release reset, tile_memory_read_data=0xA5 for address 0 -> tile enable pulses once with addr 0x000, valid=1 within 3 clk, read of addr 6 returns 0xA5, addr 7 returns 0x01.
- Write addr 4=0x10, addr 5=0x08 -> attribute enable with addr 0x010. Write 5=0x18 -> color enable with addr 0x0. Write 4=0x2F -> color addr 0xF.
- Increment=0x04, pointer=0x0000, three addr-6 reads -> fetch addresses 0x000, 0x004, 0x008, 0x00C in order; each read returns the byte of its own address.
- Pointer=0xFFFF, increment=0x02, one addr-6 read -> pointer=0x0001, tile fetch at 0x001.
- Write addr 4 while state=WAIT (MEM_READ_LATENCY=3) -> old data is not latched, valid stays 0, new REQ follows, and only the new address's data ends up in read_latch.
- Assert rst during REQ -> all enables low immediately, addr 7 reads 0x00, and after release a fetch of 0x0000 follows.

Source files
------------

// File: rtl/gpu_read_port.sv
// gpu_read_port: CPU readback path for the GPU tile, attribute and color
// memories. Snoops CPU writes to the pointer/increment registers, prefetches
// the byte at the read pointer and serves it through the data-port register
// with post-read auto-increment. Single clock domain (clk); cpu_clk is only
// sampled through a synchronizer and used to find the end of each CPU cycle.
//
// Handshake: there is no valid/ready pair on the CPU side. Software polls
// status bit0 (valid) before reading the data port; a data-port read while
// valid=0 returns the stale latch and is never stalled. Toward the memories a
// read enable is a single-cycle strobe with its address; data is taken
// MEM_READ_LATENCY cycles later without any acknowledge.
module gpu_read_port #(
  parameter int SYNC_STAGES      = 2,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk,
  input  logic        cs,
  input  logic        rw,
  input  logic [2:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_out_enable,
  output logic        tile_memory_read_enable,
  output logic [10:0] tile_memory_read_addr,
  input  logic [7:0]  tile_memory_read_data,
  output logic        attribute_memory_read_enable,
  output logic [11:0] attribute_memory_read_addr,
  input  logic [7:0]  attribute_memory_read_data,
  output logic        color_memory_read_enable,
  output logic [3:0]  color_memory_read_addr,
  input  logic [7:0]  color_memory_read_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TGT_TILE  = 2'd0,
    TGT_ATTR  = 2'd1,
    TGT_COLOR = 2'd2
  } target_t;

  // Last value of the wait counter before moving to LATCH.
  localparam logic [7:0] WAIT_LAST =
    8'((MEM_READ_LATENCY >= 2) ? (MEM_READ_LATENCY - 2) : 0);

  // Synchronizer and cycle-end detection.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_cpu_prev;
  logic                   w_cpu_fall;

  // Register-file state.
  logic [15:0] r_ptr;
  logic [7:0]  r_inc;
  logic [7:0]  r_latch;
  logic        r_valid;
  logic        r_init;

  // Fetch engine.
  state_t      r_state;
  state_t      w_state_next;
  target_t     r_target;
  target_t     w_sel_next;
  logic [7:0]  r_wait_cnt;
  logic [10:0] r_tile_addr;
  logic [11:0] r_attr_addr;
  logic [3:0]  r_color_addr;

  // Decoded CPU events, valid only on the cycle-end clk.
  logic        w_wr_inc;
  logic        w_wr_lo;
  logic        w_wr_hi;
  logic        w_rd_data;
  logic        w_trigger;
  logic [15:0] w_ptr_next;
  logic [11:0] w_attr_off;
  logic [7:0]  w_mem_data;
  logic        w_busy;

  // Bring cpu_clk into clk and keep one extra flop to spot its falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync     <= '0;
      r_cpu_prev <= 1'b0;
    end else begin
      r_sync[0] <= cpu_clk;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_cpu_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_cpu_fall = r_cpu_prev & ~r_sync[SYNC_STAGES-1];

  assign w_wr_inc  = w_cpu_fall & ~cs & ~rw & (addr == 3'd3);
  assign w_wr_lo   = w_cpu_fall & ~cs & ~rw & (addr == 3'd4);
  assign w_wr_hi   = w_cpu_fall & ~cs & ~rw & (addr == 3'd5);
  assign w_rd_data = w_cpu_fall & ~cs &  rw & (addr == 3'd6);

  // Any pointer change (or the post-reset kick) restarts the prefetch.
  assign w_trigger = r_init | w_wr_lo | w_wr_hi | w_rd_data;

  // Pointer value that takes effect on this clk; also the prefetch address.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_wr_lo) begin
      w_ptr_next = {r_ptr[15:8], data_in};
    end else if (w_wr_hi) begin
      w_ptr_next = {data_in, r_ptr[7:0]};
    end else if (w_rd_data) begin
      w_ptr_next = r_ptr + {8'h00, r_inc};
    end
  end

  assign w_attr_off = w_ptr_next[11:0] - 12'h800;

  // Memory map decode of the address about to be fetched.
  always_comb begin
    w_sel_next = TGT_COLOR;
    if (w_ptr_next < 16'h0800) begin
      w_sel_next = TGT_TILE;
    end else if (w_ptr_next < 16'h1800) begin
      w_sel_next = TGT_ATTR;
    end
  end

  // One-shot kick that starts the prefetch of 0x0000 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init <= 1'b1;
    end else begin
      r_init <= 1'b0;
    end
  end

  // Pointer and increment registers updated from snooped CPU cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 16'h0000;
      r_inc <= 8'h01;
    end else begin
      if (w_wr_inc) begin
        r_inc <= data_in;
      end
      if (w_wr_lo | w_wr_hi | w_rd_data) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  // Capture target memory and its address at the start of each fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_target     <= TGT_TILE;
      r_tile_addr  <= 11'h000;
      r_attr_addr  <= 12'h000;
      r_color_addr <= 4'h0;
    end else if (w_trigger) begin
      r_target <= w_sel_next;
      case (w_sel_next)
        TGT_TILE: r_tile_addr  <= w_ptr_next[10:0];
        TGT_ATTR: r_attr_addr  <= w_attr_off;
        default:  r_color_addr <= w_ptr_next[3:0];
      endcase
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fetch FSM next state; a trigger in any state restarts at REQ.
  always_comb begin
    w_state_next = r_state;
    if (w_trigger) begin
      w_state_next = S_REQ;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_IDLE;
        S_REQ: begin
          if (MEM_READ_LATENCY <= 1) begin
            w_state_next = S_LATCH;
          end else begin
            w_state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_next = S_LATCH;
          end
        end
        S_LATCH: w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Count cycles spent in WAIT; cleared whenever WAIT is not continuing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 8'h00;
    end else if ((r_state == S_WAIT) && !w_trigger) begin
      r_wait_cnt <= r_wait_cnt + 8'h01;
    end else begin
      r_wait_cnt <= 8'h00;
    end
  end

  // Select returned data from the memory this fetch targeted.
  always_comb begin
    w_mem_data = color_memory_read_data;
    case (r_target)
      TGT_TILE: w_mem_data = tile_memory_read_data;
      TGT_ATTR: w_mem_data = attribute_memory_read_data;
      default:  w_mem_data = color_memory_read_data;
    endcase
  end

  // Data latch and valid flag; a trigger discards any in-flight result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_latch <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_trigger) begin
      r_valid <= 1'b0;
    end else if (r_state == S_LATCH) begin
      r_latch <= w_mem_data;
      r_valid <= 1'b1;
    end
  end

  assign w_busy = (r_state != S_IDLE);

  // Single-cycle strobes, only in REQ and only to the latched target.
  assign tile_memory_read_enable      = (r_state == S_REQ) && (r_target == TGT_TILE);
  assign attribute_memory_read_enable = (r_state == S_REQ) && (r_target == TGT_ATTR);
  assign color_memory_read_enable     = (r_state == S_REQ) && (r_target == TGT_COLOR);
  assign tile_memory_read_addr        = r_tile_addr;
  assign attribute_memory_read_addr   = r_attr_addr;
  assign color_memory_read_addr       = r_color_addr;

  assign data_out_enable = ~cs & rw & ((addr == 3'd6) | (addr == 3'd7));

  // CPU read mux: data port and status register.
  always_comb begin
    data_out = 8'h00;
    case (addr)
      3'd6:    data_out = r_latch;
      3'd7:    data_out = {6'b000000, w_busy, r_valid};
      default: data_out = 8'h00;
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_gpu_read_port.sv
// Directed bench for gpu_read_port. Two instances share the CPU bus: dut_a
// with single-cycle memories, dut_b with three-cycle memories for the
// abort-in-WAIT case. Memory models return a fixed function of the address.
module tb_gpu_read_port;

  logic        clk;
  logic        rst;
  logic        cpu_clk;
  logic        cs;
  logic        rw;
  logic [2:0]  addr;
  logic [7:0]  data_in;

  logic [7:0]  a_data_out, b_data_out;
  logic        a_data_out_enable, b_data_out_enable;
  logic        a_tile_en, b_tile_en;
  logic [10:0] a_tile_addr, b_tile_addr;
  logic [7:0]  a_tile_data, b_tile_data;
  logic        a_attr_en, b_attr_en;
  logic [11:0] a_attr_addr, b_attr_addr;
  logic [7:0]  a_attr_data, b_attr_data;
  logic        a_col_en, b_col_en;
  logic [3:0]  a_col_addr, b_col_addr;
  logic [7:0]  a_col_data, b_col_data;
  logic [1:0]  a_dbg_state, b_dbg_state;

  int n_assert;
  int n_fail;
  int n_multi;
  logic [15:0] a_log[$];
  logic [15:0] b_log[$];

  gpu_read_port #(.SYNC_STAGES(2), .MEM_READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .cpu_clk(cpu_clk), .cs(cs), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(a_data_out), .data_out_enable(a_data_out_enable),
    .tile_memory_read_enable(a_tile_en), .tile_memory_read_addr(a_tile_addr),
    .tile_memory_read_data(a_tile_data),
    .attribute_memory_read_enable(a_attr_en), .attribute_memory_read_addr(a_attr_addr),
    .attribute_memory_read_data(a_attr_data),
    .color_memory_read_enable(a_col_en), .color_memory_read_addr(a_col_addr),
    .color_memory_read_data(a_col_data), .dbg_state(a_dbg_state)
  );

  gpu_read_port #(.SYNC_STAGES(2), .MEM_READ_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .cpu_clk(cpu_clk), .cs(cs), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(b_data_out), .data_out_enable(b_data_out_enable),
    .tile_memory_read_enable(b_tile_en), .tile_memory_read_addr(b_tile_addr),
    .tile_memory_read_data(b_tile_data),
    .attribute_memory_read_enable(b_attr_en), .attribute_memory_read_addr(b_attr_addr),
    .attribute_memory_read_data(b_attr_data),
    .color_memory_read_enable(b_col_en), .color_memory_read_addr(b_col_addr),
    .color_memory_read_data(b_col_data), .dbg_state(b_dbg_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required end within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] tile_byte(input logic [10:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] attr_byte(input logic [11:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] color_byte(input logic [3:0] a);
    return {4'h9, a};
  endfunction

  function automatic logic [15:0] enc(input logic [1:0] id, input logic [11:0] a);
    return {id, 2'b00, a};
  endfunction

  // Memory models, latency 1 for dut_a.
  always @(posedge clk) begin
    if (a_tile_en) a_tile_data <= tile_byte(a_tile_addr);
    if (a_attr_en) a_attr_data <= attr_byte(a_attr_addr);
    if (a_col_en)  a_col_data  <= color_byte(a_col_addr);
  end

  // Memory models, latency 3 for dut_b.
  logic [7:0] bt1, bt2, ba1, ba2, bc1, bc2;
  always @(posedge clk) begin
    bt1 <= b_tile_en ? tile_byte(b_tile_addr) : 8'hEE;
    ba1 <= b_attr_en ? attr_byte(b_attr_addr) : 8'hEE;
    bc1 <= b_col_en  ? color_byte(b_col_addr) : 8'hEE;
    bt2 <= bt1; ba2 <= ba1; bc2 <= bc1;
    b_tile_data <= bt2; b_attr_data <= ba2; b_col_data <= bc2;
  end

  // Fetch monitors: log every strobe, flag overlapping strobes.
  always @(posedge clk) begin
    if (a_tile_en) a_log.push_back(enc(2'd0, {1'b0, a_tile_addr}));
    if (a_attr_en) a_log.push_back(enc(2'd1, a_attr_addr));
    if (a_col_en)  a_log.push_back(enc(2'd2, {8'h00, a_col_addr}));
    if (b_tile_en) b_log.push_back(enc(2'd0, {1'b0, b_tile_addr}));
    if (b_attr_en) b_log.push_back(enc(2'd1, b_attr_addr));
    if (b_col_en)  b_log.push_back(enc(2'd2, {8'h00, b_col_addr}));
    if ($countones({a_tile_en, a_attr_en, a_col_en}) > 1) n_multi++;
    if ($countones({b_tile_en, b_attr_en, b_col_en}) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_a(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    v = 16'hFFFF;
    if (a_log.size() > 0) v = a_log.pop_front();
    check(tag, v, exp);
  endtask

  task automatic pop_b(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    v = 16'hFFFF;
    if (b_log.size() > 0) v = b_log.pop_front();
    check(tag, v, exp);
  endtask

  // Combinational register peek with no cpu_clk edge (no side effects).
  task automatic peek(input logic [2:0] a, output logic [7:0] da,
                      output logic [7:0] db, output logic ea);
    cs = 1'b0; rw = 1'b1; addr = a;
    #1;
    da = a_data_out; db = b_data_out; ea = a_data_out_enable;
    cs = 1'b1; rw = 1'b1; addr = 3'd0;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b0; rw = 1'b0; addr = a; data_in = d; cpu_clk = 1'b1;
    repeat (3) @(negedge clk);
    cpu_clk = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1; rw = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b0; rw = 1'b1; addr = a; cpu_clk = 1'b1;
    repeat (3) @(negedge clk);
    #1 d = a_data_out;
    cpu_clk = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1; rw = 1'b1;
  endtask

  // Poll status bit0 of one instance with a cycle bound.
  task automatic wait_valid(input string tag, input bit use_b, input int max_cyc,
                            output int cyc);
    logic [7:0] da, db;
    logic ea;
    logic ok;
    ok = 1'b0;
    cyc = 0;
    while (cyc < max_cyc && !ok) begin
      @(negedge clk);
      cyc++;
      peek(3'd7, da, db, ea);
      ok = use_b ? db[0] : da[0];
    end
    check(tag, {15'd0, ok}, 16'd1);
  endtask

  logic [7:0] da, db, rd;
  logic ea;
  int cyc;
  logic [7:0] exp_rd[3];

  initial begin
    n_assert = 0; n_fail = 0; n_multi = 0;
    cs = 1'b1; rw = 1'b1; addr = 3'd0; data_in = 8'h00; cpu_clk = 1'b0; rst = 1'b0;
    exp_rd[0] = 8'hA5; exp_rd[1] = 8'hA1; exp_rd[2] = 8'hAD;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_tile_en", {15'd0, a_tile_en}, 16'd0);
    check("rst_attr_en", {15'd0, a_attr_en}, 16'd0);
    check("rst_col_en", {15'd0, a_col_en}, 16'd0);
    check("rst_tile_addr", {5'd0, a_tile_addr}, 16'h0000);
    peek(3'd7, da, db, ea);
    check("rst_status", {8'd0, da}, 16'h0000);

    // Release and initial prefetch of 0x0000.
    @(negedge clk);
    rst = 1'b1;
    wait_valid("init_valid", 1'b0, 10, cyc);
    check("init_latency", cyc[15:0], 16'd3);
    pop_a("init_fetch", enc(2'd0, 12'h000));
    check("init_fetch_count", a_log.size(), 16'd0);
    peek(3'd6, da, db, ea);
    check("init_data", {8'd0, da}, 16'h00A5);
    check("init_data_oe", {15'd0, ea}, 16'd1);
    peek(3'd7, da, db, ea);
    check("init_status", {8'd0, da}, 16'h0001);
    peek(3'd2, da, db, ea);
    check("other_addr_data", {8'd0, da}, 16'h0000);
    check("other_addr_oe", {15'd0, ea}, 16'd0);

    // Memory map decode.
    a_log.delete();
    cpu_write(3'd4, 8'h10);
    cpu_write(3'd5, 8'h08);
    wait_valid("attr_valid", 1'b0, 10, cyc);
    pop_a("tile_fetch_0010", enc(2'd0, 12'h010));
    pop_a("attr_fetch_010", enc(2'd1, 12'h010));
    peek(3'd6, da, db, ea);
    check("attr_data", {8'd0, da}, 16'h002C);
    cpu_write(3'd5, 8'h18);
    wait_valid("color0_valid", 1'b0, 10, cyc);
    pop_a("color_fetch_0", enc(2'd2, 12'h000));
    peek(3'd6, da, db, ea);
    check("color0_data", {8'd0, da}, 16'h0090);
    cpu_write(3'd4, 8'h2F);
    wait_valid("colorF_valid", 1'b0, 10, cyc);
    pop_a("color_fetch_F", enc(2'd2, 12'h00F));
    peek(3'd6, da, db, ea);
    check("colorF_data", {8'd0, da}, 16'h009F);

    // Auto-increment by 4 from 0x0000.
    cpu_write(3'd3, 8'h04);
    cpu_write(3'd5, 8'h00);
    wait_valid("ptr_hi0_valid", 1'b0, 10, cyc);
    a_log.delete();
    cpu_write(3'd4, 8'h00);
    wait_valid("ptr0_valid", 1'b0, 10, cyc);
    for (int i = 0; i < 3; i++) begin
      cpu_read(3'd6, rd);
      check($sformatf("incr_read_%0d", i), {8'd0, rd}, {8'd0, exp_rd[i]});
      wait_valid($sformatf("incr_valid_%0d", i), 1'b0, 10, cyc);
    end
    pop_a("incr_fetch_000", enc(2'd0, 12'h000));
    pop_a("incr_fetch_004", enc(2'd0, 12'h004));
    pop_a("incr_fetch_008", enc(2'd0, 12'h008));
    pop_a("incr_fetch_00C", enc(2'd0, 12'h00C));
    peek(3'd6, da, db, ea);
    check("incr_data_00C", {8'd0, da}, 16'h00A9);

    // Pointer wrap: 0xFFFF + 2 -> 0x0001.
    cpu_write(3'd3, 8'h02);
    cpu_write(3'd5, 8'hFF);
    cpu_write(3'd4, 8'hFF);
    wait_valid("ffff_valid", 1'b0, 10, cyc);
    a_log.delete();
    cpu_read(3'd6, rd);
    check("ffff_read", {8'd0, rd}, 16'h009F);
    wait_valid("wrap_valid", 1'b0, 10, cyc);
    pop_a("wrap_fetch_001", enc(2'd0, 12'h001));
    peek(3'd6, da, db, ea);
    check("wrap_data", {8'd0, da}, 16'h00A4);

    // Increment of zero refetches the same address.
    cpu_write(3'd3, 8'h00);
    a_log.delete();
    cpu_read(3'd6, rd);
    check("inc0_read", {8'd0, rd}, 16'h00A4);
    wait_valid("inc0_valid", 1'b0, 10, cyc);
    pop_a("inc0_fetch_001", enc(2'd0, 12'h001));

    // Abort during WAIT on the latency-3 instance.
    wait_valid("b_idle_valid", 1'b1, 20, cyc);
    b_log.delete();
    @(negedge clk);
    cs = 1'b0; rw = 1'b0; addr = 3'd4; data_in = 8'h40; cpu_clk = 1'b1;
    repeat (3) @(negedge clk);
    cpu_clk = 1'b0;
    @(negedge clk);
    cpu_clk = 1'b1;
    @(negedge clk);
    cpu_clk = 1'b0;
    @(negedge clk);
    data_in = 8'h80;
    @(negedge clk);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    peek(3'd7, da, db, ea);
    check("abort_status", {8'd0, db}, 16'h0002);
    wait_valid("abort_valid", 1'b1, 20, cyc);
    peek(3'd6, da, db, ea);
    check("abort_data", {8'd0, db}, 16'h0025);
    pop_b("abort_fetch_old", enc(2'd0, 12'h040));
    pop_b("abort_fetch_new", enc(2'd0, 12'h080));
    check("abort_fetch_count", b_log.size(), 16'd0);

    // Reset asserted during REQ.
    a_log.delete();
    b_log.delete();
    @(negedge clk);
    cs = 1'b0; rw = 1'b0; addr = 3'd4; data_in = 8'h33; cpu_clk = 1'b1;
    repeat (3) @(negedge clk);
    cpu_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("req_tile_en", {15'd0, a_tile_en}, 16'd1);
    check("req_tile_addr", {5'd0, a_tile_addr}, 16'h0033);
    rst = 1'b0;
    #1;
    check("rstreq_a_en", {13'd0, a_tile_en, a_attr_en, a_col_en}, 16'd0);
    check("rstreq_b_en", {13'd0, b_tile_en, b_attr_en, b_col_en}, 16'd0);
    check("rstreq_tile_addr", {5'd0, a_tile_addr}, 16'h0000);
    peek(3'd7, da, db, ea);
    check("rstreq_status_a", {8'd0, da}, 16'h0000);
    check("rstreq_status_b", {8'd0, db}, 16'h0000);
    cs = 1'b1; rw = 1'b1;
    repeat (3) @(negedge clk);
    check("rstreq_no_strobe_a", a_log.size(), 16'd0);
    check("rstreq_no_strobe_b", b_log.size(), 16'd0);
    rst = 1'b1;
    wait_valid("rerst_valid", 1'b0, 10, cyc);
    check("rerst_latency", cyc[15:0], 16'd3);
    pop_a("rerst_fetch", enc(2'd0, 12'h000));
    peek(3'd6, da, db, ea);
    check("rerst_data", {8'd0, da}, 16'h00A5);

    check("single_strobe", n_multi[15:0], 16'd0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
